instr_fetch_decode: RTL and testbench
=====================================

INSTR_FETCH_DECODE -- requirements
Module: instr_fetch_decode

Interface
REQ-001 SHALL have ports:
- clk  input  1  rising-edge clock
- reset  input  1  reset, synchronous, active-high
- prog_we  input  1  program-memory write strobe
- prog_addr  input  4  program-memory write address
- prog_data  input  8  program-memory write data
- start  input  1  begin or resume execution
- pc_in  input  4  current PC from program counter
- opcode  output  2  decoded opcode to PC (11 = branch)
- set_value  output  4  branch target to PC
- instr_out  output  8  full fetched instruction word
- pc_reset  output  1  holds program counter at 0
- running  output  1  high in RUN
- halted  output  1  high in HALT
- retired_count  output  8  instructions executed since last start
REQ-002 Instruction format SHALL be [7:6] opcode, [5:4] register field, [3:0] immediate/target.

Function
REQ-003 SHALL contain a 16x8 program memory with one synchronous write port and an asynchronous read port addressed by pc_in.
REQ-004 SHALL implement states LOAD, RUN, HALT with 2-bit state register.
REQ-005 LOAD: prog_we=1 SHALL write prog_data to mem[prog_addr] at the clock edge; start=1 -> RUN next cycle.
REQ-006 prog_we and start asserted in the same LOAD cycle SHALL both take effect: write committed, then RUN.
REQ-007 RUN: prog_we SHALL be ignored; start SHALL be ignored.
REQ-008 RUN: instr_out = mem[pc_in]; opcode = mem[pc_in][7:6]; set_value = mem[pc_in][3:0]; combinational, zero latency.
REQ-009 LOAD/HALT: instr_out = 8'h00, opcode = 2'b00, set_value = 4'h0.
REQ-010 pc_reset SHALL equal reset OR (state != RUN), combinational.
REQ-011 Halt detection: in RUN, opcode==11 AND set_value==pc_in (jump-to-self) SHALL transition to HALT next cycle.
REQ-012 HALT: prog_we SHALL write memory as in LOAD; start=1 -> RUN next cycle.
REQ-013 retired_count SHALL increment by 1 on every clock edge spent in RUN, including the halting instruction's cycle.
REQ-014 retired_count SHALL saturate at 8'hFF, no wrap.
REQ-015 retired_count SHALL clear to 0 on the edge that enters RUN from LOAD or HALT.
REQ-016 retired_count SHALL hold its value in LOAD and HALT.
REQ-017 running = (state==RUN); halted = (state==HALT); mutually exclusive.
REQ-018 Branch to a different address or non-branch opcodes SHALL NOT affect state.

Reset
REQ-019 reset=1 at a clock edge SHALL force state LOAD, retired_count 0, and all 16 memory words to 8'h00, overriding prog_we and start.
REQ-020 Reset asserted mid-RUN or mid-HALT SHALL take effect at that edge; pc_reset asserts combinationally with reset.
REQ-021 After reset: running=0, halted=0, pc_reset=1, opcode=00, set_value=0, instr_out=00.

Verification
REQ-022 Reset, write mem[0]=8'h05, mem[1]=8'hC1 (JMP 1), pulse start -> RUN; with PC model: opcode 00 at pc 0, then 11/set_value 1 at pc 1, HALT next edge, retired_count=2, pc_reset=1.
REQ-023 prog_we=1 addr 3 data 8'hAA while RUN -> mem[3] unchanged, verified after return to LOAD via reset is n/a; instead verify via HALT and rerun reading 00 at pc 3.
REQ-024 Program of 16 non-branch words run 300 cycles -> retired_count saturates at 8'hFF, PC wraps 15->0, state stays RUN.
REQ-025 HALT, then start -> RUN next edge, retired_count=0 on that edge, pc_reset deasserts, PC restarts at 0.
REQ-026 Reset asserted in RUN with retired_count=7 -> next edge: LOAD, count 0, mem[*]=00, outputs per REQ-021.
REQ-027 Same-cycle prog_we (addr 0, 8'hC0) and start in LOAD -> RUN, first fetch is 8'hC0, HALT after one RUN cycle, retired_count=1.

Source files
------------

// File: rtl/instr_fetch_decode.sv
// Tiny program store with LOAD/RUN/HALT sequencing. It decodes the word at pc_in for an
// external program counter and counts retired instructions.
module instr_fetch_decode (
  input  logic       clk,
  input  logic       reset,
  input  logic       prog_we,
  input  logic [3:0] prog_addr,
  input  logic [7:0] prog_data,
  input  logic       start,
  input  logic [3:0] pc_in,
  output logic [1:0] opcode,
  output logic [3:0] set_value,
  output logic [7:0] instr_out,
  output logic       pc_reset,
  output logic       running,
  output logic       halted,
  output logic [7:0] retired_count
);

  typedef enum logic [1:0] {
    ST_LOAD = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  state_t     state_r;
  logic [7:0] mem_r [16];
  logic [7:0] retired_r;
  logic [7:0] fetch_s;
  logic [7:0] word_s;
  logic       halt_hit_s;

  assign fetch_s = mem_r[pc_in];

  // Present the fetched word only while executing; otherwise hand the PC a harmless NOP
  always_comb begin
    word_s = 8'h00;
    if (state_r == ST_RUN) begin
      word_s = fetch_s;
    end else begin
      word_s = 8'h00;
    end
  end

  // A branch whose target is its own address is the program's way of saying "stop"
  assign halt_hit_s    = (word_s[7:6] == 2'b11) && (word_s[3:0] == pc_in);

  assign instr_out     = word_s;
  assign opcode        = word_s[7:6];
  assign set_value     = word_s[3:0];
  assign pc_reset      = reset | (state_r != ST_RUN);
  assign running       = (state_r == ST_RUN);
  assign halted        = (state_r == ST_HALT);
  assign retired_count = retired_r;

  // Sequencer, program memory writes and retired-instruction counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_LOAD;
      retired_r <= 8'h00;
      for (int i = 0; i < 16; i++) begin
        mem_r[4'(i)] <= 8'h00;
      end
    end else begin
      case (state_r)
        ST_LOAD, ST_HALT: begin
          if (prog_we) begin
            mem_r[prog_addr] <= prog_data;
          end
          if (start) begin
            state_r   <= ST_RUN;
            retired_r <= 8'h00;
          end
        end
        ST_RUN: begin
          if (retired_r != 8'hFF) begin
            retired_r <= retired_r + 8'd1;
          end
          if (halt_hit_s) begin
            state_r <= ST_HALT;
          end
        end
        default: begin
          state_r <= ST_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Randomized and directed bench for instr_fetch_decode. It compares the DUT every cycle
// against a behavioural model of the sequencer plus an external program-counter model.
module tb_instr_fetch_decode;

  logic       clk = 1'b0;
  logic       reset;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic       start;
  logic [3:0] pc_in;
  logic [1:0] opcode;
  logic [3:0] set_value;
  logic [7:0] instr_out;
  logic       pc_reset;
  logic       running;
  logic       halted;
  logic [7:0] retired_count;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: mode 0=LOAD 1=RUN 2=HALT
  int         mode_m;
  int         cnt_m;
  logic [7:0] mem_m [16];
  logic [3:0] pc_m;
  logic [7:0] last_instr;

  instr_fetch_decode dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .pc_in(pc_in), .opcode(opcode),
    .set_value(set_value), .instr_out(instr_out), .pc_reset(pc_reset),
    .running(running), .halted(halted), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return {7'd0, instr_out, opcode, set_value, pc_reset, running, halted, retired_count};
  endfunction

  task automatic model_reset();
    mode_m = 0;
    cnt_m  = 0;
    pc_m   = 4'd0;
    for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
  endtask

  // One clock: drive inputs, compare combinational outputs, then advance model and PC
  task automatic step(input logic r, input logic w, input logic [3:0] a,
                      input logic [7:0] d, input logic s, input string tag);
    logic       run;
    logic       pr;
    logic [7:0] word;
    @(negedge clk);
    reset = r; prog_we = w; prog_addr = a; prog_data = d; start = s; pc_in = pc_m;
    #1;
    run  = (mode_m == 1);
    word = run ? mem_m[pc_m] : 8'h00;
    pr   = r | !run;
    check_val(tag, dut_vec(),
              {7'd0, word, word[7:6], word[3:0], pr, run, (mode_m == 2), cnt_m[7:0]});
    last_instr = instr_out;
    @(posedge clk);
    if (pr) pc_m = 4'd0;
    else if (word[7:6] == 2'b11) pc_m = word[3:0];
    else pc_m = pc_m + 4'd1;
    if (r) begin
      model_reset();
    end else if (!run) begin
      if (w) mem_m[a] = d;
      if (s) begin
        mode_m = 1;
        cnt_m  = 0;
      end
    end else begin
      if (cnt_m < 255) cnt_m++;
      if (word[7:6] == 2'b11 && word[3:0] == pc_in) mode_m = 2;
    end
    #1;
  endtask

  task automatic idle(input string tag);
    step(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, tag);
  endtask

  task automatic write(input logic [3:0] a, input logic [7:0] d);
    step(1'b0, 1'b1, a, d, 1'b0, "load_wr");
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, "reset");
  endtask

  function automatic logic [7:0] rand_nonbranch();
    logic [7:0] v;
    v = 8'($urandom);
    if (v[7:6] == 2'b11) v[7:6] = 2'b10;
    return v;
  endfunction

  initial begin
    reset = 1'b1; prog_we = 1'b0; prog_addr = 4'd0; prog_data = 8'h00;
    start = 1'b0; pc_in = 4'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_outs", dut_vec(), 32'h0000_0400);

    // JMP-to-self at address 1 halts after two retired instructions
    do_reset();
    write(4'd0, 8'h05);
    write(4'd1, 8'hC1);
    step(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, "r22_start");
    idle("r22_pc0");
    idle("r22_pc1");
    check_val("r22_state", {29'd0, halted, running, pc_reset}, 32'd5);
    check_val("r22_cnt", {24'd0, retired_count}, 32'd2);

    // writes during RUN are dropped; rerun from HALT reads 00 at address 3
    do_reset();
    write(4'd0, 8'h05);
    write(4'd4, 8'hC4);
    step(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, "r23_start");
    step(1'b0, 1'b1, 4'd3, 8'hAA, 1'b0, "r23_run_wr");
    repeat (4) idle("r23_run");
    check_val("r23_halt", {31'd0, halted}, 32'd1);
    check_val("r23_cnt", {24'd0, retired_count}, 32'd5);
    step(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, "r25_start");
    check_val("r25_run", {29'd0, halted, running, pc_reset}, 32'd2);
    check_val("r25_cnt", {24'd0, retired_count}, 32'd0);
    repeat (3) idle("r23_rerun");
    idle("r23_pc3");
    check_val("r23_mem3", {24'd0, last_instr}, 32'd0);

    // saturation with a branch-free program; PC wraps 15 -> 0
    do_reset();
    for (int i = 0; i < 16; i++) write(4'(i), rand_nonbranch());
    step(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, "r24_start");
    for (int i = 0; i < 300; i++)
      step(1'b0, 1'($urandom), 4'($urandom), 8'($urandom), 1'($urandom), "r24_run");
    check_val("r24_sat", {24'd0, retired_count}, 32'hFF);
    check_val("r24_run", {31'd0, running}, 32'd1);

    // reset in RUN clears state, counter and memory
    idle("r26_prep");
    do_reset();
    for (int i = 0; i < 16; i++) write(4'(i), rand_nonbranch());
    step(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, "r26_start");
    repeat (7) idle("r26_run");
    check_val("r26_cnt7", {24'd0, retired_count}, 32'd7);
    do_reset();
    check_val("r26_outs", dut_vec(), 32'h0000_0400);
    step(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, "r26_start2");
    repeat (16) idle("r26_memclr");

    // simultaneous write and start in LOAD
    do_reset();
    step(1'b0, 1'b1, 4'd0, 8'hC0, 1'b1, "r27_wr_start");
    idle("r27_pc0");
    check_val("r27_instr", {24'd0, last_instr}, 32'hC0);
    check_val("r27_halt", {31'd0, halted}, 32'd1);
    check_val("r27_cnt", {24'd0, retired_count}, 32'd1);

    // random programs with branches, restarts and occasional resets
    for (int round = 0; round < 30; round++) begin
      do_reset();
      for (int i = 0; i < 16; i++) begin
        if ($urandom_range(0, 3) == 0) write(4'(i), {4'hC, 4'($urandom)});
        else write(4'(i), 8'($urandom));
      end
      step(1'b0, 1'($urandom), 4'($urandom), 8'($urandom), 1'b1, "rnd_start");
      for (int c = 0; c < 60; c++)
        step(($urandom_range(0, 63) == 0), 1'($urandom), 4'($urandom), 8'($urandom),
             ($urandom_range(0, 7) == 0), "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
